// File: rtl/case_unique_checker.sv
// Unique-case checker: classifies one (sel, range) item per transfer against a range arm and a literal arm.
// Latency: result registered, out_valid asserts exactly 1 cycle after the input transfer.
// Backpressure: single register stage; in_ready = stage empty or out_ready, so full throughput when downstream is ready.
// Optional feature macro: CASE_CHK_COUNT_EN (violation counter; viol_cnt tied to 0 when undefined).

module case_unique_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sel,
   input  logic [3:0]       range_start,
   input  logic [3:0]       range_end,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_code,
   output logic             out_overlap,
   output logic             out_nomatch,
   output logic [CNT_W-1:0] viol_cnt,
   input  logic             cnt_clr
);

   // Output register occupancy
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Arm codes as presented on out_code
   localparam logic [4:0] CODE_ARM_A    = 5'd16;
   localparam logic [4:0] CODE_ARM_B    = 5'd17;
   localparam logic [4:0] CODE_DEFAULT  = 5'd18;
   localparam logic [3:0] ARM_B_VALUE   = 4'd8;

   logic [0:0] state_q;
   logic [0:0] state_d;

   logic       arm_a;
   logic       arm_b;
   logic [4:0] code_d;
   logic       overlap_d;
   logic       nomatch_d;

   logic       in_fire;
   logic       out_fire;

   // Arm decode on the live inputs; an inverted range is empty, not wrapped
   always_comb begin
      arm_a     = (range_start <= range_end) &&
                  (sel >= range_start) && (sel <= range_end);
      arm_b     = (sel == ARM_B_VALUE);
      overlap_d = arm_a && arm_b;
      nomatch_d = !arm_a && !arm_b;
      if (arm_a) begin
         code_d = CODE_ARM_A;
      end else if (arm_b) begin
         code_d = CODE_ARM_B;
      end else begin
         code_d = CODE_DEFAULT;
      end
   end

   // Handshake: accept when the stage is empty or being drained; never while in reset
   always_comb begin
      out_valid = (state_q == ST_FULL);
      in_ready  = !rst && ((state_q == ST_EMPTY) || out_ready);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
   end

   // Next state: a new item always leaves the stage full; a drain alone empties it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (in_fire) begin
               state_d = ST_FULL;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Result register: loads only on an input transfer, otherwise holds its last value
   always_ff @(posedge clk) begin
      if (rst) begin
         out_code    <= 5'd0;
         out_overlap <= 1'b0;
         out_nomatch <= 1'b0;
      end else if (in_fire) begin
         out_code    <= code_d;
         out_overlap <= overlap_d;
         out_nomatch <= nomatch_d;
      end
   end

`ifdef CASE_CHK_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic             viol_hit;

   // An accepted item is a violation when the arms overlap or nothing but default matched
   always_comb begin
      viol_hit = in_fire && (overlap_d || nomatch_d);
   end

   // Saturating violation counter; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (viol_hit && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign viol_cnt = cnt_q;
`else
   logic unused_cnt_clr;

   // Counter disabled: the clear input has no effect
   assign unused_cnt_clr = cnt_clr;
   assign viol_cnt       = '0;
`endif

endmodule

// File: tb/tb_case_unique_checker.sv
module tb_case_unique_checker;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       sel = 4'd0;
   logic [3:0]       range_start = 4'd0;
   logic [3:0]       range_end = 4'd0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [4:0]       out_code;
   logic             out_overlap;
   logic             out_nomatch;
   logic [CNT_W-1:0] viol_cnt;
   logic             cnt_clr = 1'b0;

   always #5 clk = ~clk;

   case_unique_checker #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sel         (sel),
      .range_start (range_start),
      .range_end   (range_end),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_code    (out_code),
      .out_overlap (out_overlap),
      .out_nomatch (out_nomatch),
      .viol_cnt    (viol_cnt),
      .cnt_clr     (cnt_clr)
   );

   typedef struct packed {
      logic [4:0] code;
      logic       ov;
      logic       nm;
   } res_t;

   res_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_cnt = 0;
   bit   prev_fire = 1'b0;
   bit   prev_rst = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: arm A is an inclusive unsigned window, arm B the literal 8
   function automatic res_t ref_model(input int s, input int rs, input int re);
      res_t r;
      bit a, b;
      a = (s >= rs) && (s <= re);
      b = (s == 8);
      r.code = a ? 5'd16 : (b ? 5'd17 : 5'd18);
      r.ov   = a && b;
      r.nm   = !a && !b;
      return r;
   endfunction

   // One clock of stimulus, plus the checks and model update tied to that clock
   task automatic step(input logic iv, input logic [3:0] s, input logic [3:0] rs,
                       input logic [3:0] re, input logic ordy, input logic clr,
                       input logic r);
      res_t e;
      bit   fire;
      @(posedge clk);
      #1;
      in_valid = iv; sel = s; range_start = rs; range_end = re;
      out_ready = ordy; cnt_clr = clr; rst = r;
      @(negedge clk);
      #1;
      chk("viol_cnt", int'(viol_cnt), exp_cnt);
      if (prev_fire) chk("latency_out_valid", int'(out_valid), 1);
      if (prev_rst) begin
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_code", int'(out_code), 0);
         chk("rst_out_flags", int'({out_overlap, out_nomatch}), 0);
      end
      prev_rst  = r;
      prev_fire = 1'b0;
      if (r) begin
         chk("rst_in_ready", int'(in_ready), 0);
         q.delete();
         exp_cnt = 0;
      end else begin
         chk("in_ready", int'(in_ready), int'(!out_valid || ordy));
         fire = iv && in_ready;
         e = ref_model(int'(s), int'(rs), int'(re));
         if (fire) q.push_back(e);
         prev_fire = fire;
`ifdef CASE_CHK_COUNT_EN
         if (clr) exp_cnt = 0;
         else if (fire && (e.ov || e.nm) && exp_cnt < CNT_MAX) exp_cnt++;
`endif
      end
   endtask

   // Monitor: pops on each output transfer and checks held outputs stay stable under backpressure
   bit         hold_prev = 1'b0;
   logic [6:0] held;
   always @(negedge clk) begin
      res_t e;
      if (hold_prev && !rst) begin
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_outputs", int'({out_code, out_overlap, out_nomatch}), int'(held));
      end
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = q.pop_front();
            chk("out_code", int'(out_code), int'(e.code));
            chk("out_overlap", int'(out_overlap), int'(e.ov));
            chk("out_nomatch", int'(out_nomatch), int'(e.nm));
         end
      end
      hold_prev = out_valid && !out_ready && !rst;
      held      = {out_code, out_overlap, out_nomatch};
   end

   initial begin
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0, 0);
      // Basic arm A hit, overlap, inverted range, default arm
      step(1, 4'd5, 4'd3, 4'd7, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 4'd8, 4'd6, 4'd9, 1, 0, 0);
      step(1, 4'd8, 4'd9, 4'd2, 1, 0, 0);
      step(1, 4'd0, 4'd1, 4'd15, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      // Backpressure: stage full, downstream stalled for 3 cycles
      step(1, 4'd4, 4'd4, 4'd4, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 4'd1, 4'd2, 4'd3, 0, 0, 0);
         chk("stall_in_ready", int'(in_ready), 0);
      end
      step(1, 4'd8, 4'd0, 4'd15, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      // Saturation, then clear alongside a violating item
      for (int i = 0; i < 5; i++) step(1, 4'd0, 4'd1, 4'd15, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
`ifdef CASE_CHK_COUNT_EN
      chk("saturated", int'(viol_cnt), CNT_MAX);
`else
      chk("cnt_disabled", int'(viol_cnt), 0);
`endif
      step(1, 4'd0, 4'd1, 4'd15, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("clr_priority", int'(viol_cnt), 0);
      // Reset while full discards the held item
      step(1, 4'd15, 4'd15, 4'd15, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 4'd0, 4'd1, 4'd2, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] s, rs, re;
         s  = ($urandom_range(3, 0) == 0) ? 4'd8 : 4'($urandom_range(15, 0));
         rs = 4'($urandom_range(15, 0));
         re = 4'($urandom_range(15, 0));
         step(1'($urandom_range(3, 0) != 0), s, rs, re,
              1'($urandom_range(3, 0) != 0), 1'($urandom_range(49, 0) == 0),
              1'($urandom_range(199, 0) == 0));
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
      chk("drain_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
